imem_fetch_ctrl: RTL and testbench

- Fetch sequencer and program loader for the byte-wide instruction memory feeding the IF stage of the 5-stage MIPS pipeline.
- After reset it streams a program into instruction memory over a byte handshake, then generates the fetch PC.
- In run mode it handles pipeline stall, branch/jump redirect with flush, and address/alignment faults.
- Replaces the hard-coded reset-time preload and the free-running PC.

---
 rtl/imem_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: program loader for the byte-wide instruction memory and
// fetch-PC sequencer (stall, branch/jump redirect with flush, fault trap).
module imem_fetch_ctrl #(
   parameter int unsigned MEM_BYTES = 64,
   parameter int unsigned ADDR_W    = 6,
   parameter logic [31:0] RESET_PC  = 32'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic              jump,
   input  logic [31:0]       jump_target,
   output logic [31:0]       pc,
   output logic              fetch_valid,
   output logic              flush,
   output logic              busy,
   output logic              fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } state_t;

   // Highest legal fetch address and the last loadable byte address
   localparam logic [31:0]       LAST_WORD = 32'(MEM_BYTES - 4);
   localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   count_q, count_d;
   logic [31:0]         pc_d;
   logic                fetch_valid_d, flush_d, busy_d, fault_d;
   logic                mem_we_d;
   logic [ADDR_W-1:0]   mem_waddr_d;
   logic [7:0]          mem_wdata_d;
   logic [31:0]         cand;
   logic                cand_bad;

   assign load_ready = (state_q == LOAD);

   // Candidate next PC by redirect priority, and its legality
   always_comb begin
      if (branch_taken)
         cand = branch_target;
      else if (jump)
         cand = jump_target;
      else if (stall)
         cand = pc;
      else
         cand = pc + 32'd4;
      cand_bad = (cand[1:0] != 2'b00) || (cand > LAST_WORD);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      pc_d          = pc;
      fetch_valid_d = 1'b0;
      flush_d       = 1'b0;
      busy_d        = busy;
      fault_d       = fault;
      mem_we_d      = 1'b0;
      mem_waddr_d   = mem_waddr;
      mem_wdata_d   = mem_wdata;

      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = LOAD;
               count_d = '0;
               busy_d  = 1'b1;
            end
         end
         LOAD: begin
            if (load_valid && load_ready) begin
               mem_we_d    = 1'b1;
               mem_waddr_d = count_q;
               mem_wdata_d = load_data;
               count_d     = count_q + ADDR_W'(1);
               if (load_last || (count_q == LAST_BYTE)) begin
                  state_d = RUN;
                  pc_d    = RESET_PC;
                  busy_d  = 1'b0;
                  flush_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (load_start) begin
               state_d = LOAD;
               count_d = '0;
               busy_d  = 1'b1;
               flush_d = 1'b1;
            end else if (cand_bad) begin
               state_d = FAULT;
               fault_d = 1'b1;
               flush_d = 1'b1;
            end else begin
               pc_d          = cand;
               fetch_valid_d = ~stall;
               flush_d       = branch_taken | jump;
            end
         end
         FAULT: begin
            if (load_start) begin
               state_d = LOAD;
               count_d = '0;
               busy_d  = 1'b1;
               fault_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         pc          <= RESET_PC;
         fetch_valid <= 1'b0;
         flush       <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
         mem_we      <= 1'b0;
         mem_waddr   <= '0;
         mem_wdata   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         pc          <= pc_d;
         fetch_valid <= fetch_valid_d;
         flush       <= flush_d;
         busy        <= busy_d;
         fault       <= fault_d;
         mem_we      <= mem_we_d;
         mem_waddr   <= mem_waddr_d;
         mem_wdata   <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a behavioural model queues the
// expected per-cycle status, memory writes and fetch addresses; a monitor
// pops and compares them as the DUT presents its outputs.
module tb_imem_fetch_ctrl;

   localparam int unsigned MEM_BYTES = 64;
   localparam int unsigned ADDR_W    = 6;
   localparam logic [31:0] RESET_PC  = 32'd0;

   logic              clk, rst;
   logic              load_start, load_valid, load_last, load_ready;
   logic [7:0]        load_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem_wdata;
   logic              stall, branch_taken, jump;
   logic [31:0]       branch_target, jump_target, pc;
   logic              fetch_valid, flush, busy, fault;

   imem_fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .busy(busy), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy;
      logic        fault;
      logic        lr;
      logic        fv;
      logic        flush;
      logic        we;
      logic [31:0] pc;
   } status_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   status_t     st_q[$];
   wr_t         wr_q[$];
   logic [31:0] fetch_q[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Behavioural model: what the controller is doing, not how
   bit          m_loading, m_running, m_faulted;
   int          m_cnt;
   logic [31:0] m_pc;
   logic [7:0]  m_mem   [MEM_BYTES];
   bit          m_wr    [MEM_BYTES];
   logic [7:0]  obs_mem [MEM_BYTES];

   logic [7:0]  prog [8] = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h8C, 8'h02, 8'h00, 8'h01};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 1'b0;
      m_running = 1'b0;
      m_faulted = 1'b0;
      m_cnt     = 0;
      m_pc      = RESET_PC;
      st_q.delete();
      wr_q.delete();
      fetch_q.delete();
   endtask

   // Apply the rules for one clock to the current inputs; queue the outcome
   task automatic model_step();
      status_t     e;
      bit          fv, fl, we;
      logic [31:0] cand;
      fv = 1'b0; fl = 1'b0; we = 1'b0;
      if (m_loading) begin
         if (load_valid) begin
            we = 1'b1;
            wr_q.push_back('{addr: ADDR_W'(m_cnt), data: load_data});
            m_mem[m_cnt] = load_data;
            m_wr[m_cnt]  = 1'b1;
            if (load_last || m_cnt == int'(MEM_BYTES) - 1) begin
               m_loading = 1'b0;
               m_running = 1'b1;
               m_pc      = RESET_PC;
               fl        = 1'b1;
            end
            m_cnt++;
         end
      end else if (m_running) begin
         if (load_start) begin
            m_running = 1'b0;
            m_loading = 1'b1;
            m_cnt     = 0;
            fl        = 1'b1;
         end else begin
            if (branch_taken)  cand = branch_target;
            else if (jump)     cand = jump_target;
            else if (stall)    cand = m_pc;
            else               cand = m_pc + 32'd4;
            if ((cand % 32'd4) != 32'd0 || cand > 32'(MEM_BYTES - 4)) begin
               m_running = 1'b0;
               m_faulted = 1'b1;
               fl        = 1'b1;
            end else begin
               m_pc = cand;
               fl   = branch_taken | jump;
               if (!stall) begin
                  fv = 1'b1;
                  fetch_q.push_back(cand);
               end
            end
         end
      end else if (load_start) begin
         m_loading = 1'b1;
         m_faulted = 1'b0;
         m_cnt     = 0;
      end
      e = '{busy: m_loading, fault: m_faulted, lr: m_loading, fv: fv,
            flush: fl, we: we, pc: m_pc};
      st_q.push_back(e);
   endtask

   task automatic clear_in();
      load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
      stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_target = 32'd0; jump_target = 32'd0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: pop expectations as the DUT presents each cycle's outputs
   always @(posedge clk) begin
      status_t e;
      wr_t     w;
      if (mon_en) begin
         #3;
         if (st_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL status_queue actual=empty required=entry");
         end else begin
            e = st_q.pop_front();
            check("busy", 64'(busy), 64'(e.busy));
            check("fault", 64'(fault), 64'(e.fault));
            check("load_ready", 64'(load_ready), 64'(e.lr));
            check("fetch_valid", 64'(fetch_valid), 64'(e.fv));
            check("flush", 64'(flush), 64'(e.flush));
            check("mem_we", 64'(mem_we), 64'(e.we));
            check("pc", 64'(pc), 64'(e.pc));
         end
         if (mem_we) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL write_queue actual=write required=none");
            end else begin
               w = wr_q.pop_front();
               check("mem_waddr", 64'(mem_waddr), 64'(w.addr));
               check("mem_wdata", 64'(mem_wdata), 64'(w.data));
               obs_mem[mem_waddr] = mem_wdata;
            end
         end
         if (fetch_valid) begin
            if (fetch_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL fetch_queue actual=fetch required=none");
            end else begin
               check("fetch_pc", 64'(pc), 64'(fetch_q.pop_front()));
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pc"}, 64'(pc), 64'(RESET_PC));
      check({tag, "_fetch_valid"}, 64'(fetch_valid), 64'd0);
      check({tag, "_flush"}, 64'(flush), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_fault"}, 64'(fault), 64'd0);
      check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      check({tag, "_mem_waddr"}, 64'(mem_waddr), 64'd0);
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({tag, "_load_ready"}, 64'(load_ready), 64'd0);
   endtask

   initial begin
      clear_in();
      rst = 1'b0;
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
         m_wr[i] = 1'b0; m_mem[i] = 8'h00; obs_mem[i] = 8'h00;
      end
      model_reset();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      mon_en = 1'b1;
      ticks(2);

      // Program load of 8 bytes, last flagged on byte 8
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         load_valid = 1'b1; load_data = prog[i]; load_last = (i == 7);
         tick();
      end
      clear_in();
      check("load_exit_pc", 64'(pc), 64'd0);
      check("load_exit_flush", 64'(flush), 64'd1);
      ticks(2);

      // Stall holds pc at 8 for 3 cycles
      stall = 1'b1; ticks(3); stall = 1'b0;
      check("stall_pc", 64'(pc), 64'h8);
      check("stall_fetch_valid", 64'(fetch_valid), 64'd0);
      tick();
      check("post_stall_pc", 64'(pc), 64'hC);

      // Branch beats stall; branch beats jump
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20; tick(); clear_in();
      check("branch_stall_pc", 64'(pc), 64'h20);
      tick();
      branch_taken = 1'b1; branch_target = 32'h20; jump = 1'b1; jump_target = 32'h10;
      tick(); clear_in();
      check("branch_jump_pc", 64'(pc), 64'h20);
      tick();

      // Misaligned jump traps and holds pc
      jump = 1'b1; jump_target = 32'h06; tick(); clear_in();
      check("fault_flag", 64'(fault), 64'd1);
      check("fault_pc", 64'(pc), 64'h24);
      ticks(2);
      load_start = 1'b1; tick(); load_start = 1'b0;
      check("reload_busy", 64'(busy), 64'd1);
      check("reload_fault", 64'(fault), 64'd0);

      // 70 bytes without last: forced end after 64
      for (int i = 0; i < 70; i++) begin
         load_valid = 1'b1; load_data = 8'($urandom);
         tick();
      end
      clear_in();
      check("forced_end_load_ready", 64'(load_ready), 64'd0);
      check("forced_end_busy", 64'(busy), 64'd0);

      // Sequential run until the last word, then trap
      ticks(20);
      check("seq_end_pc", 64'(pc), 64'd60);
      check("seq_end_fault", 64'(fault), 64'd1);

      // Reset mid-load after 3 bytes
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1; load_data = 8'($urandom); tick();
      end
      clear_in();
      mon_en = 1'b0;
      #4 rst = 1'b1;
      #1;
      check_reset_outputs("midload_rst");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // Randomised traffic across all modes
      for (int n = 0; n < 600; n++) begin
         load_start   = ($urandom_range(99) < 3);
         load_valid   = ($urandom_range(99) < 70);
         load_data    = 8'($urandom);
         load_last    = ($urandom_range(99) < 10);
         stall        = ($urandom_range(99) < 25);
         branch_taken = ($urandom_range(99) < 8);
         jump         = ($urandom_range(99) < 8);
         branch_target = ($urandom_range(99) < 85) ? 32'($urandom_range(15) * 4) : 32'($urandom);
         jump_target   = ($urandom_range(99) < 85) ? 32'($urandom_range(15) * 4)
                                                   : 32'($urandom_range(15) * 4 + $urandom_range(1, 3));
         tick();
      end
      clear_in();
      mon_en = 1'b0;
      #5;

      check("status_queue_drained", 64'(st_q.size()), 64'd0);
      check("write_queue_drained", 64'(wr_q.size()), 64'd0);
      check("fetch_queue_drained", 64'(fetch_q.size()), 64'd0);
      for (int i = 0; i < int'(MEM_BYTES); i++)
         if (m_wr[i]) check("mem_image", 64'(obs_mem[i]), 64'(m_mem[i]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
